// File: rtl/axis_cpu_ctl.sv
// Command-stream controller for a small cluster of CPU cores: program load, reset hold,
// run/single-step gating and register dump over an AXI-Stream-style debug port.
module axis_cpu_ctl #(
    parameter int N_CORES         = 4,
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int INST_WIDTH      = 8,
    parameter int NUM_DBG_REGS    = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                cmd_in_TDATA,
    input  logic                       cmd_in_TVALID,
    output logic [31:0]                cmd_out_TDATA,
    output logic                       cmd_out_TVALID,
    output logic [N_CORES-1:0]         hold_in_rst,
    output logic [N_CORES-1:0]         step_en,
    input  logic [N_CORES-1:0]         inst_rd_en,
    output logic [CODE_ADDR_WIDTH-1:0] prog_addr,
    output logic [INST_WIDTH-1:0]      prog_inst,
    output logic [N_CORES-1:0]         prog_inst_wr_en,
    output logic [31:0]                prog_imm,
    output logic [N_CORES-1:0]         prog_imm_wr_en,
    output logic [7:0]                 dbg_rd_addr,
    input  logic [32*N_CORES-1:0]      dbg_rd_data,
    output logic [31:0]                dbg_TDATA,
    output logic                       dbg_TVALID,
    input  logic                       dbg_TREADY,
    output logic                       dbg_TLAST
);

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_SET_ADDR = 4'd1;
    localparam logic [3:0] OP_WR_INST  = 4'd2;
    localparam logic [3:0] OP_WR_IMM   = 4'd3;
    localparam logic [3:0] OP_HOLD     = 4'd4;
    localparam logic [3:0] OP_RELEASE  = 4'd5;
    localparam logic [3:0] OP_STEP     = 4'd6;
    localparam logic [3:0] OP_RUN      = 4'd7;
    localparam logic [3:0] OP_DUMP     = 4'd8;
    localparam logic [7:0] LAST_K      = 8'(NUM_DBG_REGS - 1);

    typedef enum logic [2:0] {S_IDLE, S_IMM_WAIT, S_DUMP_RD, S_DUMP_CAP, S_DUMP_OUT} state_t;

    state_t               state_r;
    logic                 inc_pend_r;
    logic                 dropped_r;
    logic [3:0]           imm_sel_r;
    logic [N_CORES-1:0]   imm_mask_r;
    logic [3:0]           dump_core_r;
    logic [N_CORES-1:0]   run_r;
    logic [15:0]          step_cnt_r [N_CORES];

    logic [3:0]           op_s;
    logic [3:0]           sel_s;
    logic [23:0]          payload_s;
    logic                 core_op_s;
    logic                 bad_core_s;
    logic [3:0]           status_s;
    logic [N_CORES-1:0]   mask_s;
    logic                 cmd_ok_s;
    logic [CODE_ADDR_WIDTH-1:0] addr_eff_s;
    logic [31:0]          dbg_slice_s;

    // Command decode; NOP and SET_ADDR ignore sel, so only core-addressed ops can be bad-core
    always_comb begin
        op_s       = cmd_in_TDATA[31:28];
        sel_s      = cmd_in_TDATA[27:24];
        payload_s  = cmd_in_TDATA[23:0];
        core_op_s  = (op_s >= OP_WR_INST) && (op_s <= OP_DUMP);
        bad_core_s = (sel_s == 4'hF) ? (op_s == OP_DUMP) : (sel_s >= 4'(N_CORES));
        if (op_s > OP_DUMP) begin
            status_s = 4'd2;
        end else if (core_op_s && bad_core_s) begin
            status_s = 4'd1;
        end else begin
            status_s = 4'd0;
        end
        mask_s = {N_CORES{1'b0}};
        for (int i = 0; i < N_CORES; i++) begin
            mask_s[i] = (sel_s == 4'hF) || (sel_s == 4'(i));
        end
        cmd_ok_s   = cmd_in_TVALID && (state_r == S_IDLE) && (status_s == 4'd0);
        // The post-write increment lands one cycle late, so a back-to-back write sees it early
        addr_eff_s = prog_addr + {{(CODE_ADDR_WIDTH-1){1'b0}}, inc_pend_r};
    end

    // Step gate and dump word selection
    always_comb begin
        step_en     = {N_CORES{1'b0}};
        dbg_slice_s = 32'd0;
        for (int i = 0; i < N_CORES; i++) begin
            step_en[i] = run_r[i] | (step_cnt_r[i] != 16'd0);
            if (dump_core_r == 4'(i)) begin
                dbg_slice_s = dbg_rd_data[32*i +: 32];
            end else begin
                dbg_slice_s = dbg_slice_s;
            end
        end
    end

    // Per-core run flag and step counter; a control command wins over a same-cycle fetch pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_r <= {N_CORES{1'b0}};
            for (int i = 0; i < N_CORES; i++) step_cnt_r[i] <= 16'd0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (cmd_ok_s && mask_s[i] &&
                    (op_s == OP_HOLD || op_s == OP_STEP || op_s == OP_RUN)) begin
                    case (op_s)
                        OP_HOLD: begin run_r[i] <= 1'b0; step_cnt_r[i] <= 16'd0; end
                        OP_STEP: begin run_r[i] <= 1'b0; step_cnt_r[i] <= payload_s[15:0]; end
                        OP_RUN:  run_r[i] <= 1'b1;
                        default: run_r[i] <= run_r[i];
                    endcase
                end else if (!run_r[i] && step_cnt_r[i] != 16'd0 && inst_rd_en[i]) begin
                    step_cnt_r[i] <= step_cnt_r[i] - 16'd1;
                end
            end
        end
    end

    // Main control FSM: command execution, acks, program writes and dump streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_IDLE;
            inc_pend_r      <= 1'b0;
            dropped_r       <= 1'b0;
            imm_sel_r       <= 4'd0;
            imm_mask_r      <= {N_CORES{1'b0}};
            dump_core_r     <= 4'd0;
            hold_in_rst     <= {N_CORES{1'b1}};
            prog_addr       <= {CODE_ADDR_WIDTH{1'b0}};
            prog_inst       <= {INST_WIDTH{1'b0}};
            prog_inst_wr_en <= {N_CORES{1'b0}};
            prog_imm        <= 32'd0;
            prog_imm_wr_en  <= {N_CORES{1'b0}};
            cmd_out_TVALID  <= 1'b0;
            cmd_out_TDATA   <= 32'd0;
            dbg_rd_addr     <= 8'd0;
            dbg_TDATA       <= 32'd0;
            dbg_TVALID      <= 1'b0;
            dbg_TLAST       <= 1'b0;
        end else begin
            prog_inst_wr_en <= {N_CORES{1'b0}};
            prog_imm_wr_en  <= {N_CORES{1'b0}};
            cmd_out_TVALID  <= 1'b0;
            inc_pend_r      <= 1'b0;
            prog_addr       <= addr_eff_s;
            case (state_r)
                S_IDLE: begin
                    if (cmd_in_TVALID) begin
                        cmd_out_TVALID <= 1'b1;
                        cmd_out_TDATA  <= {op_s, sel_s, status_s, dropped_r, 3'b000, 16'(addr_eff_s)};
                        if (status_s == 4'd0) begin
                            case (op_s)
                                OP_NOP:      if (payload_s[0]) dropped_r <= 1'b0;
                                OP_SET_ADDR: prog_addr <= payload_s[CODE_ADDR_WIDTH-1:0];
                                OP_WR_INST: begin
                                    prog_inst       <= payload_s[INST_WIDTH-1:0];
                                    prog_inst_wr_en <= mask_s;
                                    inc_pend_r      <= 1'b1;
                                end
                                OP_WR_IMM: begin
                                    imm_sel_r  <= sel_s;
                                    imm_mask_r <= mask_s;
                                    state_r    <= S_IMM_WAIT;
                                end
                                OP_HOLD:    hold_in_rst <= hold_in_rst | mask_s;
                                OP_RELEASE: hold_in_rst <= hold_in_rst & ~mask_s;
                                OP_DUMP: begin
                                    dump_core_r <= sel_s;
                                    dbg_rd_addr <= 8'd0;
                                    state_r     <= S_DUMP_RD;
                                end
                                default: state_r <= S_IDLE;
                            endcase
                        end
                    end
                end
                S_IMM_WAIT: begin
                    if (cmd_in_TVALID) begin
                        cmd_out_TVALID <= 1'b1;
                        cmd_out_TDATA  <= {OP_WR_IMM, imm_sel_r, 4'd0, dropped_r, 3'b000, 16'(addr_eff_s)};
                        prog_imm       <= cmd_in_TDATA;
                        prog_imm_wr_en <= imm_mask_r;
                        inc_pend_r     <= 1'b1;
                        state_r        <= S_IDLE;
                    end
                end
                S_DUMP_RD: state_r <= S_DUMP_CAP;
                S_DUMP_CAP: begin
                    dbg_TDATA  <= dbg_slice_s;
                    dbg_TVALID <= 1'b1;
                    dbg_TLAST  <= (dbg_rd_addr == LAST_K);
                    state_r    <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (dbg_TREADY) begin
                        dbg_TVALID <= 1'b0;
                        dbg_TLAST  <= 1'b0;
                        if (dbg_rd_addr == LAST_K) begin
                            state_r <= S_IDLE;
                        end else begin
                            dbg_rd_addr <= dbg_rd_addr + 8'd1;
                            state_r     <= S_DUMP_RD;
                        end
                    end
                end
                default: state_r <= S_IDLE;
            endcase
            if (cmd_in_TVALID && (state_r == S_DUMP_RD || state_r == S_DUMP_CAP ||
                                  state_r == S_DUMP_OUT)) begin
                dropped_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_cpu_ctl.sv
// Self-checking bench for axis_cpu_ctl: directed scenarios plus random command traffic
// compared against a transaction-level model of the controller.
module tb_axis_cpu_ctl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cmd_in_TDATA;
    logic         cmd_in_TVALID;
    logic [31:0]  cmd_out_TDATA;
    logic         cmd_out_TVALID;
    logic [3:0]   hold_in_rst, step_en, inst_rd_en;
    logic [9:0]   prog_addr;
    logic [7:0]   prog_inst;
    logic [3:0]   prog_inst_wr_en;
    logic [31:0]  prog_imm;
    logic [3:0]   prog_imm_wr_en;
    logic [7:0]   dbg_rd_addr;
    logic [127:0] dbg_rd_data = 128'd0;
    logic [31:0]  dbg_TDATA;
    logic         dbg_TVALID, dbg_TREADY, dbg_TLAST;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0]  m_addr;
    logic [3:0]  m_hold;
    bit          m_run [4];
    int          m_cnt [4];
    bit          m_dropped;
    bit          m_imm_pend;
    logic [3:0]  m_imm_sel;
    logic [3:0]  m_imm_mask;
    logic [15:0] salt;

    axis_cpu_ctl dut (
        .clk(clk), .rst(rst),
        .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
        .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID),
        .hold_in_rst(hold_in_rst), .step_en(step_en), .inst_rd_en(inst_rd_en),
        .prog_addr(prog_addr), .prog_inst(prog_inst), .prog_inst_wr_en(prog_inst_wr_en),
        .prog_imm(prog_imm), .prog_imm_wr_en(prog_imm_wr_en),
        .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
        .dbg_TDATA(dbg_TDATA), .dbg_TVALID(dbg_TVALID), .dbg_TREADY(dbg_TREADY),
        .dbg_TLAST(dbg_TLAST)
    );

    always #5 clk = ~clk;

    // Debug register file with one cycle of read latency: word = {core, addr, salt}
    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) dbg_rd_data[32*c +: 32] <= {8'(c), dbg_rd_addr, salt};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_step_en();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_run[i] || (m_cnt[i] != 0);
        return r;
    endfunction

    function automatic int model_status(input logic [3:0] op, input logic [3:0] sel);
        if (op >= 4'd9) return 2;
        if (op >= 4'd2 && ((sel == 4'hF) ? (op == 4'd8) : (sel >= 4'd4))) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_addr = 10'd0; m_hold = 4'hF; m_dropped = 1'b0; m_imm_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin m_run[i] = 1'b0; m_cnt[i] = 0; end
    endtask

    task automatic model_pulses(input logic [3:0] p, input logic [3:0] skip);
        for (int i = 0; i < 4; i++)
            if (p[i] && !skip[i] && !m_run[i] && m_cnt[i] > 0) m_cnt[i]--;
    endtask

    // One accepted command beat (or WR_IMM data beat), with optional fetch pulses
    task automatic beat(input logic [31:0] w, input logic [3:0] p);
        logic [3:0]  op, sel, msk, skip, exp_inst, exp_imm;
        logic [31:0] exp_ack;
        logic [9:0]  exp_wa;
        int          st;
        op = w[31:28]; sel = w[27:24]; skip = 4'h0; exp_inst = 4'h0; exp_imm = 4'h0;
        exp_wa = m_addr;
        msk = (sel == 4'hF) ? 4'hF : ((sel < 4'd4) ? (4'h1 << sel) : 4'h0);
        if (m_imm_pend) begin
            exp_ack = {4'd3, m_imm_sel, 4'd0, m_dropped, 3'b000, 6'd0, m_addr};
            exp_imm = m_imm_mask;
            m_imm_pend = 1'b0;
            m_addr = m_addr + 10'd1;
        end else begin
            st = model_status(op, sel);
            exp_ack = {op, sel, 4'(st), m_dropped, 3'b000, 6'd0, m_addr};
            if (st == 0) begin
                case (op)
                    4'd0: if (w[0]) m_dropped = 1'b0;
                    4'd1: m_addr = w[9:0];
                    4'd2: begin exp_inst = msk; m_addr = m_addr + 10'd1; end
                    4'd3: begin m_imm_pend = 1'b1; m_imm_sel = sel; m_imm_mask = msk; end
                    4'd4: begin
                        m_hold = m_hold | msk; skip = msk;
                        for (int i = 0; i < 4; i++) if (msk[i]) begin m_run[i] = 1'b0; m_cnt[i] = 0; end
                    end
                    4'd5: m_hold = m_hold & ~msk;
                    4'd6: begin
                        skip = msk;
                        for (int i = 0; i < 4; i++) if (msk[i]) begin m_run[i] = 1'b0; m_cnt[i] = int'(w[15:0]); end
                    end
                    4'd7: begin
                        skip = msk;
                        for (int i = 0; i < 4; i++) if (msk[i]) m_run[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        model_pulses(p, skip);
        cmd_in_TDATA = w; cmd_in_TVALID = 1'b1; inst_rd_en = p;
        @(posedge clk); #1;
        cmd_in_TVALID = 1'b0; inst_rd_en = 4'h0;
        chk("ack_valid", cmd_out_TVALID, 1);
        chk("ack_word", cmd_out_TDATA, exp_ack);
        chk("inst_wr_en", prog_inst_wr_en, exp_inst);
        chk("imm_wr_en", prog_imm_wr_en, exp_imm);
        if (exp_inst != 4'h0) chk("inst_data", prog_inst, w[7:0]);
        if (exp_imm != 4'h0) chk("imm_data", prog_imm, w);
        if (exp_inst != 4'h0 || exp_imm != 4'h0) chk("write_addr", prog_addr, exp_wa);
        chk("step_en", step_en, exp_step_en());
        chk("hold_in_rst", hold_in_rst, m_hold);
    endtask

    task automatic idle(input logic [3:0] p);
        cmd_in_TVALID = 1'b0; inst_rd_en = p;
        @(posedge clk); #1;
        inst_rd_en = 4'h0;
        model_pulses(p, 4'h0);
        chk("idle_no_ack", cmd_out_TVALID, 0);
        chk("idle_no_write", {prog_inst_wr_en, prog_imm_wr_en}, 0);
        chk("idle_step_en", step_en, exp_step_en());
    endtask

    initial begin
        logic [31:0] w, held, exp_d;
        logic [3:0]  op;
        bit          hv;
        int          nb, cyc;

        rst = 1'b1; cmd_in_TDATA = 32'd0; cmd_in_TVALID = 1'b0; inst_rd_en = 4'h0;
        dbg_TREADY = 1'b0; salt = 16'($urandom);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", hold_in_rst, 4'hF);
        chk("rst_step_en", step_en, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_outs", {cmd_out_TVALID, dbg_TVALID, dbg_TLAST, prog_inst_wr_en, prog_imm_wr_en}, 0);
        chk("rst_data", cmd_out_TDATA | dbg_TDATA | prog_imm, 0);
        rst = 1'b0;
        idle(4'h0);

        // Instruction writes across the address wrap, core 1 only
        beat(32'h1000_03FF, 4'h0);
        beat(32'h2100_00A5, 4'h0);
        beat(32'h2100_005A, 4'h0);
        idle(4'h0);
        chk("addr_after_wrap", prog_addr, 10'h001);

        // Broadcast immediate write
        beat(32'h3F00_0000, 4'h0);
        beat(32'hDEAD_BEEF, 4'h0);
        idle(4'h0);

        // Release core 0 and single-step three instructions out of five fetches
        beat(32'h5000_0000, 4'h0);
        beat(32'h6000_0003, 4'h0);
        for (int k = 0; k < 5; k++) begin
            chk("step_window", step_en[0], (k < 3) ? 32'd1 : 32'd0);
            idle(4'h1);
        end

        // Bad opcode, bad core on WR_IMM, then the next beat must decode as a command
        beat(32'hC100_0000, 4'h0);
        beat(32'h3600_0000, 4'h0);
        beat(32'h2000_0011, 4'h0);

        // STEP colliding with a fetch pulse keeps the loaded count
        beat(32'h6000_0002, 4'h1);
        idle(4'h1);
        idle(4'h1);
        idle(4'h1);

        // Register dump of core 2 with a stalling consumer and a dropped command mid-dump
        beat(32'h8200_0000, 4'h0);
        nb = 0; cyc = 0; hv = 1'b0; held = 32'd0;
        while (nb < 18 && cyc < 400) begin
            dbg_TREADY = 1'($urandom % 2);
            cmd_in_TVALID = (cyc == 5); cmd_in_TDATA = 32'h2100_0077;
            if (dbg_TVALID) begin
                if (hv) chk("dump_stable", dbg_TDATA, held);
                if (dbg_TREADY) begin
                    exp_d = {8'd2, 8'(nb), salt};
                    chk("dump_data", dbg_TDATA, exp_d);
                    chk("dump_last", dbg_TLAST, (nb == 17) ? 32'd1 : 32'd0);
                    nb++; hv = 1'b0;
                end else begin
                    held = dbg_TDATA; hv = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (cyc == 5) begin
                cmd_in_TVALID = 1'b0;
                m_dropped = 1'b1;
                chk("dropped_no_ack", cmd_out_TVALID, 0);
                chk("dropped_no_write", prog_inst_wr_en, 0);
            end
            cyc++;
        end
        dbg_TREADY = 1'b0;
        chk("dump_beats", nb, 18);
        beat(32'h0000_0001, 4'h0);
        beat(32'h0000_0000, 4'h0);

        // Random command traffic against the model
        for (int n = 0; n < 200; n++) begin
            if ($urandom % 4 == 0) begin
                idle(4'($urandom));
            end else begin
                w = $urandom;
                op = w[31:28];
                if (!m_imm_pend && op == 4'd8) w[31:28] = 4'd7;
                if (!m_imm_pend && op == 4'd6) w[23:0] = 24'($urandom_range(0, 4));
                if ($urandom % 2 == 1) w[27:24] = 4'($urandom_range(0, 3));
                beat(w, 4'($urandom));
            end
        end
        if (m_imm_pend) beat(32'h0000_0000, 4'h0);

        // Reset while waiting for immediate data: the next beat is a fresh command
        beat(32'h3000_0000, 4'h0);
        rst = 1'b1; #1;
        chk("rst_imm_no_write", prog_imm_wr_en, 0);
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
        beat(32'h1000_0123, 4'h0);

        // Reset during DUMP_OUT aborts the stream immediately
        beat(32'h8100_0000, 4'h0);
        for (int i = 0; i < 10 && !dbg_TVALID; i++) begin @(posedge clk); #1; end
        chk("dump_out_reached", dbg_TVALID, 1);
        rst = 1'b1; #1;
        chk("rst_dump_tvalid", dbg_TVALID, 0);
        chk("rst_dump_tlast", dbg_TLAST, 0);
        chk("rst_dump_hold", hold_in_rst, 4'hF);
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
        idle(4'h0);
        chk("post_rst_tvalid", dbg_TVALID, 0);
        beat(32'h0000_0000, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
